// File: rtl/wb_stage.sv
// Write-back stage: commits register-file writes, owns the CP0 register set,
// resolves SYSCALL/ERET at commit and drives the pipeline flush/redirect.
module wb_stage #(
    parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ms_to_ws_valid,
    input  logic [85:0] ms_to_ws_bus,
    output logic        ws_allowin,
    output logic [3:0]  rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [9:0]  stall_ws_bus,
    output logic [32:0] forward_ws_bus,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    typedef struct packed {
        logic        bd;
        logic        exc_sys;
        logic        eret;
        logic        cp0_wen;
        logic        res_from_cp0;
        logic [7:0]  cp0_addr;
        logic [3:0]  gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_ws_t;

    localparam logic [7:0] ADDR_COUNT   = 8'h48;
    localparam logic [7:0] ADDR_COMPARE = 8'h58;
    localparam logic [7:0] ADDR_STATUS  = 8'h60;
    localparam logic [7:0] ADDR_CAUSE   = 8'h68;
    localparam logic [7:0] ADDR_EPC     = 8'h70;

    logic        ws_valid;
    ms_ws_t      ws;

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic        cause_ti;
    logic [1:0]  cause_ip;
    logic [4:0]  cause_exccode;
    logic [31:0] epc;
    logic [31:0] count;
    logic [31:0] compare;
    logic        tick;

    logic        commit;
    logic        mtc0;
    logic        do_sys;
    logic        do_eret;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;
    logic [31:0] cp0_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
        end else if (flush) begin
            ws_valid <= 1'b0;
        end else begin
            ws_valid <= ms_to_ws_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws <= '0;
        end else if (ms_to_ws_valid) begin
            ws <= ms_to_ws_bus;
        end
    end

    assign commit  = ws_valid && !ws.exc_sys;
    assign mtc0    = commit && ws.cp0_wen;
    assign do_sys  = ws_valid && ws.exc_sys;
    assign do_eret = ws_valid && ws.eret;

    // Exception/ERET updates come last so they win over an MTC0 to Status.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            status_im     <= '0;
            status_exl    <= 1'b0;
            status_ie     <= 1'b0;
            cause_bd      <= 1'b0;
            cause_ti      <= 1'b0;
            cause_ip      <= '0;
            cause_exccode <= '0;
            epc           <= '0;
            count         <= '0;
            compare       <= '0;
            tick          <= 1'b0;
        end else begin
            tick <= ~tick;
            if (mtc0 && ws.cp0_addr == ADDR_COUNT) begin
                count <= ws.result;
            end else if (tick) begin
                count <= count + 32'd1;
            end
            if (mtc0 && ws.cp0_addr == ADDR_COMPARE) begin
                compare  <= ws.result;
                cause_ti <= 1'b0;
            end else if (tick && (count + 32'd1) == compare) begin
                cause_ti <= 1'b1;
            end
            if (mtc0 && ws.cp0_addr == ADDR_EPC) begin
                epc <= ws.result;
            end
            if (mtc0 && ws.cp0_addr == ADDR_STATUS) begin
                status_im  <= ws.result[15:8];
                status_exl <= ws.result[1];
                status_ie  <= ws.result[0];
            end
            if (mtc0 && ws.cp0_addr == ADDR_CAUSE) begin
                cause_ip <= ws.result[9:8];
            end
            if (do_sys) begin
                status_exl    <= 1'b1;
                cause_exccode <= 5'd8;
                if (!status_exl) begin
                    epc      <= ws.bd ? ws.pc - 32'd4 : ws.pc;
                    cause_bd <= ws.bd;
                end
            end
            if (do_eret) begin
                status_exl <= 1'b0;
            end
        end
    end

    assign status_rd = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
    assign cause_rd  = {cause_bd, cause_ti, 14'b0, cause_ti, 5'b0,
                        cause_ip, 1'b0, cause_exccode, 2'b0};

    always_comb begin
        cp0_rdata = 32'b0;
        unique case (ws.cp0_addr)
            ADDR_COUNT:   cp0_rdata = count;
            ADDR_COMPARE: cp0_rdata = compare;
            ADDR_STATUS:  cp0_rdata = status_rd;
            ADDR_CAUSE:   cp0_rdata = cause_rd;
            ADDR_EPC:     cp0_rdata = epc;
            default:      cp0_rdata = 32'b0;
        endcase
    end

    assign ws_allowin        = 1'b1;
    assign rf_we             = {4{commit}} & ws.gr_we;
    assign rf_waddr          = ws.dest;
    assign rf_wdata          = ws.res_from_cp0 ? cp0_rdata : ws.result;
    assign stall_ws_bus      = {ws_valid && |ws.gr_we, {4{ws_valid}} & ws.gr_we, ws.dest};
    assign forward_ws_bus    = {ws_valid, rf_wdata};
    assign flush             = ws_valid && (ws.exc_sys || ws.eret);
    assign flush_pc          = ws.exc_sys ? EXC_ENTRY : epc;
    assign debug_wb_pc       = ws.pc;
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule
